// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames a byte as start/data/stop and paces an
// external shift register (which holds the frame and drives the TX line).
//
// state | meaning
// IDLE  | line idle high, ready to accept a byte
// SEND  | frame in progress, one shift per CLK_DIV cycles
module uart_tx_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int CLK_DIV   = 434
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 sr_load,
  output logic                 sr_shift_en,
  output logic [DATA_BITS+1:0] sr_data
);

  localparam int FRAME_W = DATA_BITS + 2;
  localparam int BAUD_W  = $clog2(CLK_DIV);
  localparam int BIT_W   = $clog2(FRAME_W);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              baud_last;
  logic              bit_last;

  assign baud_last = (baud_cnt == BAUD_W'(CLK_DIV - 1));
  assign bit_last  = (bit_cnt == BIT_W'(FRAME_W - 1));

  assign tx_ready    = (state == IDLE);
  assign busy        = (state == SEND);
  assign sr_load     = tx_valid & tx_ready;
  assign sr_shift_en = busy & baud_last;
  assign frame_done  = sr_shift_en & bit_last;
  // Stop bit on top, start bit at the LSB so the register shifts it out first.
  assign sr_data     = {1'b1, tx_data, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sr_load) begin
            state    <= SEND;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        SEND: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_last) begin
              state   <= IDLE;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: behavioural frame-timing model checked every cycle,
// plus literal line/timing expectations for the directed frames.
module tb_uart_tx_ctrl;

  localparam int DB = 8;
  localparam int CD = 4;
  localparam int FW = DB + 2;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          tx_valid = 0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_ready, busy, frame_done, sr_load, sr_shift_en;
  logic [FW-1:0] sr_data;
  logic [FW-1:0] sr_q;
  logic          line;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  uart_tx_ctrl #(.DATA_BITS(DB), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .frame_done(frame_done),
    .sr_load(sr_load), .sr_shift_en(sr_shift_en), .sr_data(sr_data)
  );

  // External shift register: resets to all 1s, serial_in tied high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '1;
    else if (sr_load) sr_q <= sr_data;
    else if (sr_shift_en) sr_q <= {1'b1, sr_q[FW-1:1]};
  end
  assign line = sr_q[0];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Model state: elapsed cycles since the accept edge and the expected frame bits.
  bit            m_busy = 0;
  int            m_e = 0;
  logic [FW-1:0] m_frame = '1;
  int            shift_seen = 0;
  int            accepts = 0;
  int            accept_edge = 0;
  int            prev_accept_edge = 0;
  int            done_edge = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_tx_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_sr_load", sr_load, 0);
      check("rst_sr_shift_en", sr_shift_en, 0);
      check("rst_line", line, 1);
      m_busy = 0;
      m_e = 0;
      shift_seen = 0;
    end else begin
      check("tx_ready", tx_ready, !m_busy);
      check("busy", busy, m_busy);
      check("sr_load", sr_load, tx_valid && !m_busy);
      check("sr_shift_en", sr_shift_en, m_busy && (m_e % CD == 0));
      check("frame_done", frame_done, m_busy && (m_e == FW * CD));
      check("sr_data", sr_data, {1'b1, tx_data, 1'b0});
      check("line", line, m_busy ? m_frame[(m_e - 1) / CD] : 1'b1);
      check("load_shift_excl", sr_load && sr_shift_en, 0);
      if (sr_shift_en) shift_seen++;
      if (frame_done) done_edge = cyc + 1;
      if (m_busy) begin
        if (m_e == FW * CD) begin
          check("shift_count", shift_seen, FW);
          shift_seen = 0;
          m_busy = 0;
        end else begin
          m_e++;
        end
      end else if (tx_valid) begin
        m_busy = 1;
        m_e = 1;
        m_frame = {1'b1, tx_data, 1'b0};
        accepts++;
        prev_accept_edge = accept_edge;
        accept_edge = cyc + 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send one byte from idle and check the line against a hand-written frame.
  task automatic send_literal(input logic [DB-1:0] b, input logic [FW-1:0] exp_bits, input string name);
    tx_valid = 1;
    tx_data = b;
    tick(1);
    tx_valid = 0;
    for (int k = 0; k < FW; k++) begin
      for (int j = 0; j < CD; j++) begin
        check(name, line, exp_bits[k]);
        tick(1);
      end
    end
    check({name, "_done_time"}, done_edge - accept_edge, FW * CD);
    check({name, "_ready_after"}, tx_ready, 1);
  endtask

  initial begin
    int a0;
    tick(5);
    #2 rst_n = 1;
    tick(100);

    send_literal(8'hA5, 10'b1101001010, "line_a5");
    tick(3);

    // Back-to-back under continuous valid.
    tx_valid = 1;
    tx_data = 8'h00;
    tick(1);
    tx_data = 8'hFF;
    tick(FW * CD + 1);
    tx_valid = 0;
    check("b2b_gap", accept_edge - prev_accept_edge, FW * CD + 1);
    tick(FW * CD + 5);

    // Requests during SEND must be ignored.
    a0 = accepts;
    tx_valid = 1;
    tx_data = 8'h81;
    tick(1);
    tx_data = 8'h3C;
    for (int i = 0; i < 30; i++) begin
      tx_valid = ~tx_valid;
      tick(1);
    end
    tx_valid = 0;
    check("busy_ignore_accepts", accepts - a0, 1);
    tick(FW * CD);

    // Asynchronous reset during data bit 3 (frame bit 4).
    tx_valid = 1;
    tx_data = 8'hC3;
    tick(1);
    tx_valid = 0;
    tick(4 * CD + 1);
    #2 rst_n = 0;
    #1;
    check("midrst_line", line, 1);
    check("midrst_ready", tx_ready, 1);
    check("midrst_baud_cnt", dut.baud_cnt, 0);
    check("midrst_bit_cnt", dut.bit_cnt, 0);
    tick(2);
    rst_n = 1;
    tick(2);
    send_literal(8'h55, 10'b1010101010, "line_55");
    tick(2);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if (!tx_valid || $urandom_range(0, 3) == 0) begin
        tx_valid = ($urandom_range(0, 2) != 0);
        tx_data = DB'($urandom);
      end
      tick(1);
    end
    tx_valid = 0;
    tick(FW * CD + 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
